// File: rtl/updown_counter_pkg.sv
// Shared constants and parameter legality check for the counter family.
// Mode/direction encodings are used by the top level's bound and step logic.
`ifndef COUNTER_PKG_SV
`define COUNTER_PKG_SV

// True when MAX/INIT/PRESCALE are legal for a counter of width W.
`define CNT_PARAMS_LEGAL(W, M, I, P) \
    (((M) >= 1) && ((M) <= ((2 ** (W)) - 1)) && ((I) >= 0) && ((I) <= (M)) && \
     ((P) >= 1) && ((P) <= 65535))

package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    localparam logic CNT_DOWN = 1'b0;
    localparam logic CNT_UP   = 1'b1;

endpackage

`endif

// File: rtl/updown_counter_if.sv
// Control and status bundle of updown_counter; the counter is the slave side.
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             io_en;
    logic             io_up;
    logic             io_clear;
    logic             io_load;
    logic [WIDTH-1:0] io_load_value;
    logic             io_ovf_clr;
    logic [WIDTH-1:0] io_out;
    logic             io_tc;
    logic             io_ovf;

    modport master (
        output io_en, io_up, io_clear, io_load, io_load_value, io_ovf_clr,
        input  io_out, io_tc, io_ovf
    );

    modport slave (
        input  io_en, io_up, io_clear, io_load, io_load_value, io_ovf_clr,
        output io_out, io_tc, io_ovf
    );
endinterface

// File: rtl/updown_counter_prescaler.sv
// Enable prescaler: emits one tick for every PRESCALE enabled cycles.
// restart returns the phase to zero, so the next tick is a full period away.
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, restart};
            assign tick = en;
        end else begin : g_count
            localparam logic [15:0] LAST = 16'(PRESCALE - 1);
            logic [15:0] phase_reg;

            assign tick = en && (phase_reg == LAST);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    phase_reg <= '0;
                end else if (restart) begin
                    phase_reg <= '0;
                end else if (en) begin
                    phase_reg <= tick ? 16'd0 : phase_reg + 16'd1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with wrap/saturate bounds, prescaled enable,
// terminal-count pulse and sticky overflow flag.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = (2 ** WIDTH) - 1,
    parameter int INIT     = 0,
    parameter int PRESCALE = 1,
    parameter int SATURATE = CNT_WRAP
) (
    input logic             clk,
    input logic             reset,
    updown_counter_if.slave bus
);

    generate
        if (!(`CNT_PARAMS_LEGAL(WIDTH, MAX, INIT, PRESCALE))) begin : g_bad_params
            $error("updown_counter: illegal MAX/INIT/PRESCALE for WIDTH");
        end
    endgenerate

    localparam logic [WIDTH:0]   MAX_X  = (WIDTH + 1)'(MAX);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
    localparam logic             SAT    = (SATURATE == CNT_SAT);

    logic [WIDTH-1:0] out_reg, out_next;
    logic             tc_reg, tc_next;
    logic             ovf_reg, ovf_next;
    logic             step;
    logic             restart;
    logic [WIDTH:0]   ext, inc, dec;
    logic             hit;

    assign restart = bus.io_clear || bus.io_load;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.io_en),
        .restart (restart),
        .tick    (step)
    );

    // Extra bit: inc beyond MAX covers both ==MAX and out-of-range values,
    // and the borrow of dec flags the lower bound.
    assign ext = {1'b0, out_reg};
    assign inc = ext + 1'b1;
    assign dec = ext - 1'b1;
    assign hit = (bus.io_up == CNT_UP) ? (inc > MAX_X) : dec[WIDTH];

    always_comb begin
        out_next = out_reg;
        tc_next  = 1'b0;
        ovf_next = ovf_reg;
        if (bus.io_ovf_clr) begin
            ovf_next = 1'b0;
        end
        if (bus.io_clear) begin
            out_next = '0;
        end else if (bus.io_load) begin
            out_next = ({1'b0, bus.io_load_value} > MAX_X) ? MAX_V : bus.io_load_value;
        end else if (step) begin
            if (bus.io_up == CNT_UP) begin
                out_next = hit ? (SAT ? MAX_V : '0) : inc[WIDTH-1:0];
            end else begin
                out_next = hit ? (SAT ? '0 : MAX_V) : dec[WIDTH-1:0];
            end
            tc_next = hit;
            if (hit) begin
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg <= INIT_V;
            tc_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            tc_reg  <= tc_next;
            ovf_reg <= ovf_next;
        end
    end

    assign bus.io_out = out_reg;
    assign bus.io_tc  = tc_reg;
    assign bus.io_ovf = ovf_reg;

endmodule

// File: tb/tb_updown_counter.sv
// Directed-vector bench for updown_counter: three instances cover wrap,
// saturate and prescaled configurations with hand-computed expectations.
module tb_updown_counter;

    logic clk;
    logic reset;

    int chk_cnt = 0;
    int err_cnt = 0;

    updown_counter_if #(.WIDTH(4)) bus_w ();
    updown_counter_if #(.WIDTH(4)) bus_s ();
    updown_counter_if #(.WIDTH(4)) bus_p ();

    updown_counter #(.WIDTH(4), .MAX(9), .INIT(5), .PRESCALE(1), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .bus(bus_w.slave));
    updown_counter #(.WIDTH(4), .MAX(9), .INIT(0), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .bus(bus_s.slave));
    updown_counter #(.WIDTH(4), .MAX(9), .INIT(0), .PRESCALE(3), .SATURATE(0)) u_pre (
        .clk(clk), .reset(reset), .bus(bus_p.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_w(input logic clr, input logic ld, input logic [3:0] val,
                         input logic en, input logic up, input logic oc);
        bus_w.io_clear = clr; bus_w.io_load = ld; bus_w.io_load_value = val;
        bus_w.io_en = en; bus_w.io_up = up; bus_w.io_ovf_clr = oc;
    endtask

    task automatic drv_s(input logic ld, input logic [3:0] val, input logic en, input logic up);
        bus_s.io_clear = 1'b0; bus_s.io_load = ld; bus_s.io_load_value = val;
        bus_s.io_en = en; bus_s.io_up = up; bus_s.io_ovf_clr = 1'b0;
    endtask

    task automatic drv_p(input logic ld, input logic en);
        bus_p.io_clear = 1'b0; bus_p.io_load = ld; bus_p.io_load_value = 4'd0;
        bus_p.io_en = en; bus_p.io_up = 1'b1; bus_p.io_ovf_clr = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_seq [4];
        logic       exp_tc  [4];
        logic       en_gap  [5];
        logic [3:0] exp_gap [5];

        reset = 1'b0;
        drv_w(0, 0, 0, 1, 1, 0);
        drv_s(0, 0, 0, 0);
        drv_p(0, 0);

        // Reset holds INIT even with enable high
        cyc(); cyc();
        check("rst_out", 32'(bus_w.io_out), 32'd5);
        check("rst_tc", 32'(bus_w.io_tc), 32'd0);
        check("rst_ovf", 32'(bus_w.io_ovf), 32'd0);
        check("rst_out_pre", 32'(bus_p.io_out), 32'd0);
        reset = 1'b1;
        cyc();
        check("first_step", 32'(bus_w.io_out), 32'd6);

        // Wrap up from 0 with MAX=9
        drv_w(1, 0, 0, 0, 1, 0);
        cyc();
        check("clear", 32'(bus_w.io_out), 32'd0);
        drv_w(0, 0, 0, 1, 1, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            check($sformatf("wrap_out%0d", i), 32'(bus_w.io_out), 32'(i));
            check($sformatf("wrap_tc%0d", i), 32'(bus_w.io_tc), 32'd0);
        end
        cyc();
        check("wrap_out0", 32'(bus_w.io_out), 32'd0);
        check("wrap_tc_hit", 32'(bus_w.io_tc), 32'd1);
        check("wrap_ovf", 32'(bus_w.io_ovf), 32'd1);
        drv_w(0, 0, 0, 0, 1, 0);
        cyc();
        check("tc_one_cycle", 32'(bus_w.io_tc), 32'd0);
        check("ovf_sticky", 32'(bus_w.io_ovf), 32'd1);

        // Sticky flag: set wins over clear in the same cycle
        drv_w(0, 0, 0, 0, 1, 1);
        cyc();
        check("ovf_clr", 32'(bus_w.io_ovf), 32'd0);
        drv_w(0, 1, 9, 0, 1, 0);
        cyc();
        check("load9", 32'(bus_w.io_out), 32'd9);
        drv_w(0, 0, 0, 1, 1, 1);
        cyc();
        check("hit_clr_out", 32'(bus_w.io_out), 32'd0);
        check("hit_clr_ovf", 32'(bus_w.io_ovf), 32'd1);
        drv_w(0, 0, 0, 0, 1, 1);
        cyc();
        check("clr_alone_ovf", 32'(bus_w.io_ovf), 32'd0);

        // Priority and clamp
        drv_w(0, 1, 7, 0, 1, 0);
        cyc();
        check("load7", 32'(bus_w.io_out), 32'd7);
        drv_w(1, 1, 7, 1, 1, 0);
        cyc();
        check("clear_over_load", 32'(bus_w.io_out), 32'd0);
        drv_w(0, 1, 15, 0, 1, 0);
        cyc();
        check("load_clamp", 32'(bus_w.io_out), 32'd9);

        // Down wrap from 0
        drv_w(0, 1, 0, 0, 0, 0);
        cyc();
        drv_w(0, 0, 0, 1, 0, 0);
        cyc();
        check("down_wrap_out", 32'(bus_w.io_out), 32'd9);
        check("down_wrap_tc", 32'(bus_w.io_tc), 32'd1);
        drv_w(0, 0, 0, 0, 1, 0);

        // Saturate down from 2
        drv_s(1, 2, 0, 0);
        cyc();
        check("sat_load2", 32'(bus_s.io_out), 32'd2);
        exp_seq = '{4'd1, 4'd0, 4'd0, 4'd0};
        exp_tc  = '{1'b0, 1'b0, 1'b1, 1'b1};
        drv_s(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("sat_dn_out%0d", i), 32'(bus_s.io_out), 32'(exp_seq[i]));
            check($sformatf("sat_dn_tc%0d", i), 32'(bus_s.io_tc), 32'(exp_tc[i]));
        end
        drv_s(1, 9, 0, 1);
        cyc();
        drv_s(0, 0, 1, 1);
        cyc();
        check("sat_up_out", 32'(bus_s.io_out), 32'd9);
        check("sat_up_tc", 32'(bus_s.io_tc), 32'd1);
        drv_s(0, 0, 0, 1);

        // Prescaler: a step every third enable
        drv_p(0, 1);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            check($sformatf("pre_out%0d", i), 32'(bus_p.io_out), 32'(i / 3));
        end
        en_gap  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_gap = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        for (int i = 0; i < 5; i++) begin
            drv_p(0, en_gap[i]);
            cyc();
            check($sformatf("pre_gap%0d", i), 32'(bus_p.io_out), 32'(exp_gap[i]));
        end
        // Load restarts the phase
        drv_p(0, 1);
        cyc();
        drv_p(1, 0);
        cyc();
        check("pre_load0", 32'(bus_p.io_out), 32'd0);
        drv_p(0, 1);
        cyc(); cyc();
        check("pre_restart_hold", 32'(bus_p.io_out), 32'd0);
        cyc();
        check("pre_restart_step", 32'(bus_p.io_out), 32'd1);

        // Asynchronous reset mid-operation
        drv_w(0, 0, 0, 1, 1, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out", 32'(bus_w.io_out), 32'd5);
        check("async_rst_ovf", 32'(bus_w.io_ovf), 32'd0);
        check("async_rst_pre", 32'(bus_p.io_out), 32'd0);
        cyc();
        reset = 1'b1;
        drv_p(0, 1);
        cyc(); cyc();
        check("pre_phase_reset", 32'(bus_p.io_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised successor to the fixed 4-bit free-running counter. Adds:
- configurable width and terminal value;
- up/down direction, synchronous load and clear;
- wrap or saturate mode, and an enable prescaler;
- a terminal-count pulse and a sticky overflow flag.

It is the general-purpose counter primitive for timers, address generators and event counting in the generated designs.

## Interface
Parameters:
- WIDTH, 4: counter width in bits.
- MAX, 2**WIDTH-1: terminal value. Legal range 1..2**WIDTH-1.
- INIT, 0: reset value of io_out. Must be <= MAX.
- PRESCALE, 1: enable pulses per count step. Legal range 1..2**16-1.
- SATURATE, 0: 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low. Asserting it (0) forces the reset state immediately.
- io_en  input  1  count enable, advances the prescaler.
- io_up  input  1  direction: 1 = increment, 0 = decrement.
- io_clear  input  1  synchronous clear to 0.
- io_load  input  1  synchronous load of io_load_value.
- io_load_value  input  WIDTH  load data.
- io_ovf_clr  input  1  clears io_ovf.
- io_out  output  WIDTH  current count (registered).
- io_tc  output  1  one-cycle terminal-count pulse (registered).
- io_ovf  output  1  sticky bound-hit flag (registered).

## Operation
- Reset state (while reset=0):
  - io_out=INIT, io_tc=0, io_ovf=0, prescaler=0.
  - Release is asynchronous; the first update happens on the first clk edge with reset=1.
- Priority per cycle: io_clear > io_load > step.
  - io_clear: io_out<=0, prescaler<=0, io_tc<=0.
  - io_load: io_out<=min(io_load_value, MAX), prescaler<=0, io_tc<=0.
- Prescaler:
  - Counts io_en cycles from 0 to PRESCALE-1.
  - A step fires in a cycle when io_en=1 and prescaler==PRESCALE-1; the prescaler then returns to 0.
  - PRESCALE=1: every io_en cycle is a step.
  - io_en=0: prescaler holds.
- Step, up (io_up=1):
  - io_out<MAX: io_out+1.
  - io_out==MAX: becomes 0 (SATURATE=0) or holds MAX (SATURATE=1).
- Step, down (io_up=0):
  - io_out>0: io_out-1.
  - io_out==0: becomes MAX (SATURATE=0) or holds 0 (SATURATE=1).
- Bound hit = a step taken while io_out is at the bound in the step direction.
  - Sets io_tc=1 for exactly the next cycle; otherwise io_tc=0.
  - Applies in saturate mode too: every held step pulses io_tc.
- Values above MAX:
  - Cannot arise from load, which clamps.
  - If reached by any path, an up-step treats the value as MAX.
- io_ovf:
  - Set on any bound hit.
  - Cleared by io_ovf_clr.
  - A bound hit and io_ovf_clr in the same cycle leave io_ovf=1 (set wins).
- Direction may change on any cycle; it is sampled only in step cycles.
- No internal arithmetic overflow: the increment and decrement are computed at WIDTH+1 bits and compared against MAX/0 before the update.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Latency: a step, load or clear sampled at edge N is visible on io_out after edge N. io_tc follows the same timing.
- Throughput: one step per cycle when PRESCALE=1 and io_en is held high.
- Reset mid-operation: all state returns to the reset values immediately, including the prescaler phase and io_ovf.

## Structure
- Shared package counter_pkg holds:
  - mode constants CNT_WRAP=0, CNT_SAT=1;
  - direction constants CNT_DOWN=0, CNT_UP=1;
  - a legality-check macro for MAX/INIT/PRESCALE, used by an elaboration-time assertion.
- Sub-module counter_prescaler:
  - Parameter PRESCALE; ports clk, reset, en, restart, tick.
  - Instantiated once; when PRESCALE=1 it reduces to tick=en.
- Top level contains the priority mux, bound compare, io_tc and io_ovf registers.

## Test plan
- Reset: hold reset=0 with INIT=5 and io_en=1 -> io_out=5, io_tc=0, io_ovf=0. Deassert reset -> first step at the next edge gives 6.
- Wrap up: WIDTH=4, MAX=9, SATURATE=0, io_up=1, io_en=1 from 0 -> io_out 0..9, 0. io_tc high only in the cycle io_out shows 0 after 9. io_ovf=1 afterwards.
- Saturate down: SATURATE=1, load 2, io_up=0, 4 enabled cycles -> io_out 1, 0, 0, 0. io_tc pulses on each of the two held steps.
- Prescaler: PRESCALE=3, io_en high for 9 cycles from 0 -> io_out reaches 3, incrementing every third enable. io_en gaps freeze the phase.
- Priority and clamp:
  - io_clear=1, io_load=1, io_load_value=7 in one cycle -> io_out=0.
  - io_load alone with value 15, MAX=9 -> io_out=9.
- Sticky flag: a bound hit in the same cycle as io_ovf_clr=1 -> io_ovf stays 1. io_ovf_clr alone on the next cycle -> io_ovf=0.
